// File: rtl/input_layer_sched_if.sv
// Window-datapath bus between the layer scheduler and the input_layer datapath.
interface input_layer_sched_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DIM_WIDTH  = 10
);
    logic                  il_start;
    logic [ADDR_WIDTH-1:0] il_axi_address;
    logic [DIM_WIDTH-1:0]  il_row_size;
    logic [DIM_WIDTH-1:0]  il_col_size;
    logic                  il_valid;
    logic                  il_rdy;

    // Scheduler side: launches layers, observes the window handshake.
    modport master (
        output il_start,
        output il_axi_address,
        output il_row_size,
        output il_col_size,
        input  il_valid,
        input  il_rdy
    );

    // Datapath side.
    modport slave (
        input  il_start,
        input  il_axi_address,
        input  il_row_size,
        input  il_col_size,
        output il_valid,
        output il_rdy
    );
endinterface

// File: rtl/input_layer_sched.sv
// Multi-layer scheduler for the input_layer datapath: launches one layer at a time once DDR
// data is present, counts 3x3 windows per layer, steps the DDR address by a burst-aligned
// stride, and flags bad configurations or a stalled datapath.
module input_layer_sched #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DIM_WIDTH      = 10,
    parameter int unsigned LAYER_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     Start,
    input  logic [ADDR_WIDTH-1:0]    base_address,
    input  logic [LAYER_WIDTH-1:0]   no_of_input_layers,
    input  logic [DIM_WIDTH-1:0]     row_size,
    input  logic [DIM_WIDTH-1:0]     col_size,
    input  logic                     in_layer_ddr3_data_rdy,
    input_layer_sched_if.master      il_bus,
    output logic                     busy,
    output logic [LAYER_WIDTH-1:0]   layer_idx,
    output logic                     done,
    output logic                     error,
    output logic [2*DIM_WIDTH-1:0]   win_count
);

    localparam int unsigned WinW    = 2 * DIM_WIDTH;
    // One extra bit so rounding the layer area up to 64 bytes cannot overflow.
    localparam int unsigned StrideW = 2 * DIM_WIDTH + 1;
    localparam int unsigned StallW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StLaunch,
        StRun,
        StNext,
        StFinish
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DIM_WIDTH-1:0]   row_q, row_d;
    logic [DIM_WIDTH-1:0]   col_q, col_d;
    logic [LAYER_WIDTH-1:0] count_q, count_d;
    logic [LAYER_WIDTH-1:0] idx_q, idx_d;
    logic [WinW-1:0]        win_q, win_d;
    logic [StallW-1:0]      stall_q, stall_d;
    logic                   err_q, err_d;

    logic [WinW-1:0]        exp_win;
    logic [StrideW-1:0]     area;
    logic [StrideW-1:0]     stride;
    logic                   handshake;
    logic                   bad_cfg;
    logic                   stall_expired;

    // Per-layer constants derived from the latched configuration.
    always_comb begin
        exp_win       = (WinW'(row_q) - WinW'(2)) * (WinW'(col_q) - WinW'(2));
        area          = StrideW'(row_q) * StrideW'(col_q);
        stride        = (area + StrideW'(63)) & ~StrideW'(63);
        handshake     = il_bus.il_valid & il_bus.il_rdy;
        bad_cfg       = (row_size < DIM_WIDTH'(3)) || (col_size < DIM_WIDTH'(3)) ||
                        (no_of_input_layers == '0);
        stall_expired = (stall_q == StallW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and datapath-register update for the layer sequencing FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        count_d = count_q;
        idx_d   = idx_q;
        win_d   = win_q;
        stall_d = stall_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    addr_d  = base_address;
                    row_d   = row_size;
                    col_d   = col_size;
                    count_d = no_of_input_layers;
                    idx_d   = '0;
                    win_d   = '0;
                    stall_d = '0;
                    err_d   = bad_cfg;
                    state_d = bad_cfg ? StFinish : StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (in_layer_ddr3_data_rdy) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                win_d   = '0;
                stall_d = '0;
                state_d = StRun;
            end
            StRun: begin
                if (handshake) begin
                    win_d   = win_q + WinW'(1);
                    stall_d = '0;
                    if (win_q + WinW'(1) == exp_win) begin
                        state_d = StNext;
                    end
                end else if (stall_expired) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    stall_d = stall_q + StallW'(1);
                end
            end
            StNext: begin
                if (idx_q == count_q - LAYER_WIDTH'(1)) begin
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_q + LAYER_WIDTH'(1);
                    // Wraps modulo 2^ADDR_WIDTH by truncation.
                    addr_d  = addr_q + ADDR_WIDTH'(stride);
                    state_d = StWaitRdy;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and configuration registers; reset returns everything to idle zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            win_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded straight from registered state.
    always_comb begin
        il_bus.il_start       = (state_q == StLaunch);
        il_bus.il_axi_address = addr_q;
        il_bus.il_row_size    = row_q;
        il_bus.il_col_size    = col_q;
        busy                  = (state_q != StIdle);
        done                  = (state_q == StFinish);
        error                 = err_q;
        layer_idx             = idx_q;
        win_count             = win_q;
    end

endmodule

// File: tb/tb_input_layer_sched.sv
// Directed bench for input_layer_sched: a table of whole-run configurations plus hand-written
// sequences for DDR wait, stall timeout, Start-at-done and mid-run reset.
module tb_input_layer_sched;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 10;
    localparam int unsigned LW     = 8;
    localparam int unsigned TO     = 256;
    localparam int          Budget = 20000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [LW-1:0] layers = '0;
    logic [DW-1:0] row_size = '0;
    logic [DW-1:0] col_size = '0;
    logic          ddr_rdy = 1'b1;
    logic          busy;
    logic [LW-1:0] layer_idx;
    logic          done;
    logic          error;
    logic [2*DW-1:0] win_count;

    int checks = 0;
    int errors = 0;

    input_layer_sched_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();

    input_layer_sched #(
        .ADDR_WIDTH    (AW),
        .DIM_WIDTH     (DW),
        .LAYER_WIDTH   (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .Start                 (start),
        .base_address          (base_address),
        .no_of_input_layers    (layers),
        .row_size              (row_size),
        .col_size              (col_size),
        .in_layer_ddr3_data_rdy(ddr_rdy),
        .il_bus                (bus),
        .busy                  (busy),
        .layer_idx             (layer_idx),
        .done                  (done),
        .error                 (error),
        .win_count             (win_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  layers;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        exp_err;
        int          exp_starts;
        logic [31:0] exp_last_addr;
        logic [19:0] exp_win;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stride_of(input int r, input int c);
        int a;
        a = r * c;
        return 32'(((a + 63) / 64) * 64);
    endfunction

    task automatic outputs_zero(input string tag);
        check({tag, "_il_start"}, bus.il_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_layer_idx"}, layer_idx, 0);
        check({tag, "_win_count"}, win_count, 0);
        check({tag, "_addr"}, bus.il_axi_address, 0);
        check({tag, "_row"}, bus.il_row_size, 0);
        check({tag, "_col"}, bus.il_col_size, 0);
    endtask

    // Leaves the caller at the first sample after Start was taken.
    task automatic drive_start(input logic [31:0] b, input logic [7:0] n,
                               input logic [9:0] r, input logic [9:0] c);
        @(negedge clk);
        start = 1'b1;
        base_address = b;
        layers = n;
        row_size = r;
        col_size = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < Budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1);
        @(negedge clk);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int starts;
        int cyc;
        logic [31:0] stride_b;
        logic [31:0] exp_addr;
        string tag;
        tag = $sformatf("v%0d", id);
        stride_b = stride_of(int'(v.row), int'(v.col));
        drive_start(v.base, v.layers, v.row, v.col);
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_err_start"}, error, v.exp_err);
        starts = 0;
        cyc = 0;
        while (!done && cyc < Budget) begin
            if (bus.il_start) begin
                exp_addr = v.base + stride_b * 32'(starts);
                check({tag, "_launch_addr"}, bus.il_axi_address, exp_addr);
                check({tag, "_launch_idx"}, layer_idx, starts);
                starts++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_starts"}, starts, v.exp_starts);
        check({tag, "_err_done"}, error, v.exp_err);
        check({tag, "_win"}, win_count, v.exp_win);
        check({tag, "_idx_done"}, layer_idx, v.exp_err ? 8'd0 : v.layers - 8'd1);
        check({tag, "_addr_done"}, bus.il_axi_address, v.exp_last_addr);
        check({tag, "_row_latched"}, bus.il_row_size, v.row);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        int cyc;
        int hit;
        int pulsed;

        vecs[0] = '{32'h0000_1000, 8'd1, 10'd49, 10'd49, 1'b0, 1, 32'h0000_1000, 20'd2209};
        vecs[1] = '{32'h0000_1000, 8'd3, 10'd49, 10'd49, 1'b0, 3, 32'h0000_2300, 20'd2209};
        vecs[2] = '{32'h0000_1000, 8'd1, 10'd2,  10'd49, 1'b1, 0, 32'h0000_1000, 20'd0};
        vecs[3] = '{32'h0000_0000, 8'd2, 10'd3,  10'd3,  1'b0, 2, 32'h0000_0040, 20'd1};
        vecs[4] = '{32'h0000_0500, 8'd1, 10'd10, 10'd2,  1'b1, 0, 32'h0000_0500, 20'd0};
        vecs[5] = '{32'h0000_0600, 8'd0, 10'd5,  10'd5,  1'b1, 0, 32'h0000_0600, 20'd0};
        vecs[6] = '{32'hFFFF_FFC0, 8'd2, 10'd8,  10'd8,  1'b0, 2, 32'h0000_0000, 20'd36};
        vecs[7] = '{32'h0000_0020, 8'd1, 10'd3,  10'd10, 1'b0, 1, 32'h0000_0020, 20'd8};
        vecs[8] = '{32'h0000_0100, 8'd3, 10'd4,  10'd17, 1'b0, 3, 32'h0000_0200, 20'd30};

        bus.il_valid = 1'b1;
        bus.il_rdy   = 1'b1;

        // Power-on reset, with a Start pulse that must be ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        outputs_zero("por");
        start = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("por_stay_idle", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Error stays set after the failed run until a good Start is taken.
        run_vec(20, vecs[2]);
        repeat (3) @(negedge clk);
        check("a_err_sticky", error, 1);
        run_vec(21, vecs[3]);

        // DDR data absent for 100 cycles.
        ddr_rdy = 1'b0;
        drive_start(32'h40, 8'd1, 10'd3, 10'd3);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.il_start) n++;
            @(negedge clk);
        end
        check("b_no_launch", n, 0);
        check("b_busy_wait", busy, 1);
        ddr_rdy = 1'b1;
        cyc = 0;
        while (!bus.il_start && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("b_launch_seen", bus.il_start, 1);
        check("b_launch_latency", (cyc >= 1 && cyc <= 2), 1);
        wait_done("b");

        // Datapath stalls after a single handshake.
        bus.il_valid = 1'b0;
        drive_start(32'h0, 8'd1, 10'd4, 10'd4);
        cyc = 0;
        while (!bus.il_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("c_launch", bus.il_start, 1);
        @(negedge clk);
        bus.il_valid = 1'b1;
        @(negedge clk);
        bus.il_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < int'(TO) + 20) begin
            @(negedge clk);
            cyc++;
        end
        check("c_timeout_cycles", cyc, TO);
        check("c_timeout_err", error, 1);
        check("c_timeout_win", win_count, 1);
        @(negedge clk);
        bus.il_valid = 1'b1;
        check("c_err_sticky", error, 1);
        check("c_idle", busy, 0);

        // Single 49x49 layer: done timing, Start mid-run and Start at done are ignored.
        drive_start(32'h1000, 8'd1, 10'd49, 10'd49);
        n = 0;
        hit = -1;
        pulsed = 0;
        cyc = 0;
        while (!done && cyc < Budget) begin
            if (bus.il_start) begin
                n++;
                check("d_addr", bus.il_axi_address, 32'h1000);
            end
            if (hit < 0 && win_count == 20'd2209) hit = cyc;
            if (n == 1 && pulsed == 0 && !bus.il_start) begin
                start = 1'b1;
                base_address = 32'h9000;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("d_done_seen", done, 1);
        check("d_done_after_last_hs", cyc - hit, 1);
        check("d_starts", n, 1);
        check("d_err", error, 0);
        check("d_addr_done", bus.il_axi_address, 32'h1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d_start_at_done_ignored", busy, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.il_start || busy) n++;
        end
        check("d_stays_idle", n, 0);

        // Reset in the middle of layer 1 of 3.
        drive_start(32'h1000, 8'd3, 10'd49, 10'd49);
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < Budget) begin
            if (bus.il_start) n++;
            @(negedge clk);
            cyc++;
        end
        check("e_reach_layer1", layer_idx, 1);
        repeat (50) @(negedge clk);
        check("e_busy_before_rst", busy, 1);
        reset_n = 1'b0;
        #1;
        outputs_zero("e_rst");
        start = 1'b1;
        base_address = 32'h7000;
        repeat (2) @(negedge clk);
        start = 1'b0;
        outputs_zero("e_rst_start");
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.il_start || busy) n++;
        end
        check("e_no_launch_after_rst", n, 0);
        run_vec(30, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_layer_sched.md
INPUT_LAYER_SCHED -- requirements
Module: input_layer_sched

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, AXI byte-address width; DIM_WIDTH, default 10, row/column size width; LAYER_WIDTH, default 8, layer-count width; TIMEOUT_CYCLES, default 4096, stall limit in RUN.
REQ-002 SHALL have ports, one per line, as listed in REQ-003 to REQ-018.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Start  in  1  one-cycle request to begin a multi-layer run.
REQ-006 base_address  in  ADDR_WIDTH  DDR byte address of layer 0.
REQ-007 no_of_input_layers  in  LAYER_WIDTH  number of layers to process.
REQ-008 row_size, col_size  in  DIM_WIDTH each  layer dimensions in pixels.
REQ-009 in_layer_ddr3_data_rdy  in  1  DDR image data present; gates each layer launch.
REQ-010 il_start  out  1  one-cycle start pulse to the input_layer datapath.
REQ-011 il_axi_address  out  ADDR_WIDTH  current layer base address.
REQ-012 il_row_size, il_col_size  out  DIM_WIDTH each  latched dimensions.
REQ-013 il_valid, il_rdy  in  1 each  datapath window handshake (monitored only).
REQ-014 busy  out  1  run in progress.
REQ-015 layer_idx  out  LAYER_WIDTH  index of current layer.
REQ-016 done  out  1  one-cycle pulse at end of run.
REQ-017 error  out  1  sticky until next accepted Start; set on bad config or timeout.
REQ-018 win_count  out  2*DIM_WIDTH  windows handshaken in current layer.

Function
REQ-019 States SHALL be IDLE, WAIT_RDY, LAUNCH, RUN, NEXT, FINISH.
REQ-020 IDLE: Start=1 SHALL latch all configuration inputs, clear error, and go to WAIT_RDY; Start in any other state SHALL be ignored.
REQ-021 At Start, if row_size<3, col_size<3, or no_of_input_layers=0: SHALL set error=1, go to FINISH, and issue no il_start.
REQ-022 WAIT_RDY: SHALL hold until in_layer_ddr3_data_rdy=1, then go to LAUNCH.
REQ-023 LAUNCH: il_start=1 for exactly one cycle; win_count cleared; next state RUN.
REQ-024 RUN: win_count SHALL increment on every cycle with il_valid & il_rdy.
REQ-025 Expected windows SHALL be (row-2)*(col-2), computed at full 2*DIM_WIDTH width.
REQ-026 RUN: when the handshake brings win_count to the expected value, SHALL go to NEXT on the same edge.
REQ-027 Stall counter SHALL clear on each handshake; reaching TIMEOUT_CYCLES without a handshake SHALL set error=1 and go to FINISH.
REQ-028 Layer stride SHALL be row*col bytes rounded up to a multiple of 64 (one 8-beat, 64-bit burst).
REQ-029 NEXT: if layer_idx = count-1, SHALL go to FINISH; else layer_idx+1, il_axi_address += stride, then WAIT_RDY.
REQ-030 Address addition SHALL wrap modulo 2^ADDR_WIDTH without error.
REQ-031 FINISH: done=1 for one cycle; next state IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Handshakes outside RUN SHALL be ignored and SHALL NOT change win_count.
REQ-034 Start coinciding with done SHALL be ignored, because the state is FINISH, not IDLE.

Reset
REQ-035 reset_n=0 SHALL force IDLE asynchronously, in any state including mid-run.
REQ-036 Under reset, every output SHALL be 0: il_start, busy, done, error, layer_idx, win_count, il_axi_address, il_row_size, il_col_size.
REQ-037 No il_start SHALL be issued until a new Start is accepted after reset release.

Verification
REQ-038 Single layer, base 0x1000, 49x49, rdy=1: one il_start with address 0x1000; done pulses on the cycle after the 2209th handshake; error=0.
REQ-039 Three layers, base 0x1000, 49x49: il_axi_address is 0x1000, 0x1980, 0x2300 (stride 0x980); layer_idx is 0, 1, 2; exactly 3 il_start pulses; one done.
REQ-040 row_size=2: error=1 and done pulses with no il_start; a valid subsequent Start clears error.
REQ-041 ddr3_data_rdy held 0 for 100 cycles after Start: state stays WAIT_RDY with no il_start; il_start follows within 2 cycles of rdy rising.
REQ-042 il_valid stuck 0 in RUN: error=1 and done exactly TIMEOUT_CYCLES cycles after the last handshake.
REQ-043 reset_n asserted mid-layer 1 of 3: all outputs 0 immediately; Start pulses during reset are ignored; a new run restarts at layer 0 with base address.
